// File: rtl/sram_arb_pkg.sv
// Shared types, state/grant encodings and the arbitration decision for the frame-SRAM arbiter.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 19;    // SRAM word address width
    localparam int DATA_W_DEF = 12;    // RGB 4:4:4 pixel word

    // Arbiter FSM encoding, kept as plain constants so existing dumps decode the same way.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t RD_ACC = 2'd1;
    localparam arb_state_t WR_ACC = 2'd2;

    // Outcome of a decision point.
    typedef logic [1:0] grant_t;
    localparam grant_t GNT_NONE = 2'd0;
    localparam grant_t GNT_RD   = 2'd1;
    localparam grant_t GNT_WR   = 2'd2;

    // Reads win unless the buffer is full, the read streak has hit its cap,
    // or nobody is reading; an empty buffer can never produce a write.
    function automatic grant_t arb_decide(
        input logic wbuf_empty,
        input logic wbuf_full,
        input logic streak_max,
        input logic rd_req
    );
        grant_t g;
        if (!wbuf_empty && (wbuf_full || streak_max || !rd_req)) begin
            g = GNT_WR;
        end else if (rd_req) begin
            g = GNT_RD;
        end else begin
            g = GNT_NONE;
        end
        return g;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Bundle of requester-side and sram_ctrl-side signals of the frame-SRAM arbiter.
// Latency: none (wiring only).
// Backpressure: wr_ready throttles the pixel packer, rd_gnt acknowledges a held rd_req.
// Modports: slave = arbiter view (requests in, grants/memory strobes out);
//           master = environment view (pixel packer, display fetch and sram_ctrl together).
interface sram_access_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WBUF_DEPTH = 4
);
    localparam int LVL_W = $clog2(WBUF_DEPTH) + 1;

    // UART pixel-packer write path
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_overflow;
    logic [LVL_W-1:0]  wbuf_level;

    // VGA pixel-fetch read path
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    // sram_ctrl side
    logic              mem_wr_req;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        output wr_ready, wr_overflow, wbuf_level, rd_gnt, rd_rvalid, rd_rdata,
               mem_wr_req, mem_rd_req, mem_addr, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        input  wr_ready, wr_overflow, wbuf_level, rd_gnt, rd_rvalid, rd_rdata,
               mem_wr_req, mem_rd_req, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_wbuf.sv
// Synchronous write-buffer FIFO holding {addr,data} entries in arrival order.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty; full/empty come from the registered level.
// Ports: clk, rst_n; push/push_dat in; pop in, pop_dat (head, combinational) out; level/full/empty out.
module sram_wbuf #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4,                      // power of two, >= 2
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;        // idle, or push and pop together
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// Arbitrates the single-port frame SRAM between buffered UART pixel writes and VGA pixel reads.
// Latency: read data returns ACC_CYCLES+1 cycles after rd_gnt; a buffered write reaches sram_ctrl one cycle after its grant.
// Backpressure: reads wait for rd_gnt; writes are buffered and wr_ready drops when full (late writes dropped, wr_overflow sticky).
// Ports: clk, rst_n plain; everything else through bus (slave modport): wr_valid/wr_addr/wr_data/wr_ready/wr_overflow/wbuf_level,
//        rd_req/rd_addr/rd_gnt/rd_rvalid/rd_rdata, mem_wr_req/mem_rd_req/mem_addr/mem_wdata/mem_rdata.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACC_CYCLES    = 2,
    parameter int WBUF_DEPTH    = 4,
    parameter int MAX_RD_STREAK = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_access_arbiter_if.slave  bus
);

    localparam int LVL_W = $clog2(WBUF_DEPTH) + 1;
    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int STK_W = (MAX_RD_STREAK > 0) ? $clog2(MAX_RD_STREAK + 1) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_RD_STREAK);

    arb_state_t        state;
    logic [CNT_W-1:0]  acc_cnt;
    logic [STK_W-1:0]  rd_streak;

    logic              wbuf_push;
    logic              wbuf_pop;
    logic              wbuf_full;
    logic              wbuf_empty;
    logic [LVL_W-1:0]  wbuf_level;
    logic [ENT_W-1:0]  wbuf_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              dec_pt;
    grant_t            grant;

    logic              wr_overflow_q;
    logic              rd_rvalid_q;
    logic [DATA_W-1:0] rd_rdata_q;
    logic              mem_wr_req_q;
    logic              mem_rd_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // ------------------------------------------------------------------
    // Write buffer. wr_ready comes from the registered level, so a pop in
    // the same cycle does not free a slot for this cycle's push.
    // ------------------------------------------------------------------
    assign wbuf_push = bus.wr_valid & ~wbuf_full;

    sram_wbuf #(
        .WIDTH (ENT_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wbuf_push),
        .push_dat ({bus.wr_addr, bus.wr_data}),
        .pop      (wbuf_pop),
        .pop_dat  (wbuf_head),
        .level    (wbuf_level),
        .full     (wbuf_full),
        .empty    (wbuf_empty)
    );

    assign head_addr = wbuf_head[ENT_W-1:DATA_W];
    assign head_data = wbuf_head[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Decision: taken in IDLE or in the last cycle of an access, so a new
    // access starts right after the previous one with no idle cycle.
    // ------------------------------------------------------------------
    assign dec_pt   = (state == IDLE) || (acc_cnt == ACC_LAST);
    assign grant    = dec_pt ? arb_decide(wbuf_empty, wbuf_full, (rd_streak == STK_MAX), bus.rd_req)
                             : GNT_NONE;
    assign wbuf_pop = (grant == GNT_WR);

    // ------------------------------------------------------------------
    // Access FSM and registered sram_ctrl strobes. The request, address
    // and write data are held for the full ACC_CYCLES of the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else if (dec_pt) begin
            acc_cnt <= '0;
            case (grant)
                GNT_RD: begin
                    state        <= RD_ACC;
                    mem_rd_req_q <= 1'b1;
                    mem_wr_req_q <= 1'b0;
                    mem_addr_q   <= bus.rd_addr;
                end
                GNT_WR: begin
                    state        <= WR_ACC;
                    mem_wr_req_q <= 1'b1;
                    mem_rd_req_q <= 1'b0;
                    mem_addr_q   <= head_addr;
                    mem_wdata_q  <= head_data;
                end
                default: begin
                    state        <= IDLE;
                    mem_wr_req_q <= 1'b0;
                    mem_rd_req_q <= 1'b0;
                end
            endcase
        end else begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read return: sram_ctrl data is valid on the edge that ends the last
    // cycle of a read access; rd_rdata keeps its value between pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rvalid_q <= 1'b0;
            rd_rdata_q  <= '0;
        end else begin
            rd_rvalid_q <= (state == RD_ACC) && (acc_cnt == ACC_LAST);
            if ((state == RD_ACC) && (acc_cnt == ACC_LAST)) begin
                rd_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation guard: only reads granted while a write is waiting count
    // toward the streak; any write grant or an empty buffer resets it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_streak <= '0;
        end else if (wbuf_empty || (grant == GNT_WR)) begin
            rd_streak <= '0;
        end else if ((grant == GNT_RD) && (rd_streak != STK_MAX)) begin
            rd_streak <= rd_streak + 1'b1;
        end
    end

    // Sticky overflow: a word offered while the buffer was full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_overflow_q <= 1'b0;
        end else if (bus.wr_valid && wbuf_full) begin
            wr_overflow_q <= 1'b1;
        end
    end

    assign bus.wr_ready    = ~wbuf_full;
    assign bus.wr_overflow = wr_overflow_q;
    assign bus.wbuf_level  = wbuf_level;
    assign bus.rd_gnt      = (grant == GNT_RD);
    assign bus.rd_rvalid   = rd_rvalid_q;
    assign bus.rd_rdata    = rd_rdata_q;
    assign bus.mem_wr_req  = mem_wr_req_q;
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule
